// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display.
// Steps one shared BCD nibble across digits with blanking, blinking, leading-zero suppression and frame-synchronous loads.
module seg_scan_ctrl #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_in,
    input  logic        load,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  blink_mask,
    input  logic        lz_en,
    output logic [3:0]  number,
    output logic [3:0]  an,
    output logic        frame_done
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_FRAMES - 1);

    logic [CW-1:0] r_refresh_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_active;
    logic [15:0]   r_pending;
    logic          r_pend_v;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_off;

    logic          w_tick;
    logic          w_wrap;
    logic [1:0]    w_idx_nxt;
    logic [15:0]   w_active_nxt;
    logic          w_blink_off_nxt;
    logic          w_dark;

    // Digit k (k>=1) is a leading zero when it and every more-significant nibble are zero.
    function automatic logic lz_dark(input logic [15:0] a, input logic [1:0] k);
        logic z;
        z = (k != 2'd0);
        for (int j = 0; j < 4; j++) begin
            if (j >= int'(k) && a[4*j +: 4] != 4'h0) z = 1'b0;
        end
        return z;
    endfunction

    always_comb begin
        w_tick          = (r_refresh_cnt == CNT_MAX);
        w_wrap          = w_tick && (r_idx == 2'd3);
        w_idx_nxt       = w_tick ? r_idx + 2'd1 : r_idx;
        w_active_nxt    = r_active;
        w_blink_off_nxt = r_blink_off;
        if (w_wrap) begin
            if (load)          w_active_nxt = digits_in;
            else if (r_pend_v) w_active_nxt = r_pending;
            if (r_blink_cnt == BLK_MAX) w_blink_off_nxt = ~r_blink_off;
        end
        w_dark = blank_mask[w_idx_nxt]
               | (blink_mask[w_idx_nxt] & w_blink_off_nxt)
               | (lz_en & lz_dark(w_active_nxt, w_idx_nxt));
    end

    // Outputs are built from next-state values so they switch on the same edge as the digit index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_refresh_cnt <= '0;
            r_idx         <= 2'd0;
            r_active      <= 16'h0000;
            r_pending     <= 16'h0000;
            r_pend_v      <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_off   <= 1'b0;
            an            <= 4'b1111;
            number        <= 4'hF;
            frame_done    <= 1'b0;
        end else begin
            r_refresh_cnt <= w_tick ? '0 : r_refresh_cnt + CW'(1);
            r_idx         <= w_idx_nxt;
            r_active      <= w_active_nxt;
            r_blink_off   <= w_blink_off_nxt;
            if (w_wrap) begin
                r_pend_v    <= 1'b0;
                r_blink_cnt <= (r_blink_cnt == BLK_MAX) ? '0 : r_blink_cnt + BW'(1);
            end else if (load) begin
                r_pending <= digits_in;
                r_pend_v  <= 1'b1;
            end
            an         <= w_dark ? 4'b1111 : ~(4'b0001 << w_idx_nxt);
            number     <= w_dark ? 4'hF : w_active_nxt[{w_idx_nxt, 2'b00} +: 4];
            frame_done <= w_wrap;
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized and directed bench for seg_scan_ctrl against a cycle-position reference model.
module tb_seg_scan_ctrl;
    localparam int RD = 4;
    localparam int BF = 2;
    localparam int FR = 4 * RD;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits_in;
    logic        load;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic        lz_en;
    logic [3:0]  number;
    logic [3:0]  an;
    logic        frame_done;

    seg_scan_ctrl #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .load(load),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .lz_en(lz_en),
        .number(number), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: cycles since reset, committed and pending display words.
    int          m_t;
    logic [15:0] m_act;
    logic [15:0] m_pend;
    logic        m_pv;

    logic [3:0] cur_bk = 4'h0;
    logic [3:0] cur_bl = 4'h0;
    logic       cur_lz = 1'b0;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    task automatic step(input logic i_r, input logic i_l, input logic [15:0] i_d);
        int p, k;
        logic wrap, boff, dark;
        logic [3:0] e_an, e_num;
        logic e_fd;
        rst = i_r; load = i_l; digits_in = i_d;
        blank_mask = cur_bk; blink_mask = cur_bl; lz_en = cur_lz;
        @(posedge clk);
        if (i_r) begin
            m_t = 0; m_act = 16'h0; m_pend = 16'h0; m_pv = 1'b0;
            e_an = 4'hF; e_num = 4'hF; e_fd = 1'b0;
        end else begin
            p = m_t;
            wrap = (p % FR) == FR - 1;
            if (wrap) begin
                if (i_l) m_act = i_d;
                else if (m_pv) m_act = m_pend;
                m_pv = 1'b0;
            end else if (i_l) begin
                m_pend = i_d;
                m_pv = 1'b1;
            end
            m_t = p + 1;
            k = (m_t / RD) % 4;
            boff = ((m_t / FR) / BF) % 2 == 1;
            dark = cur_bk[k] || (cur_bl[k] && boff)
                || (cur_lz && k > 0 && (m_act >> (4 * k)) == 16'h0);
            e_an  = dark ? 4'hF : ~(4'(1) << k);
            e_num = dark ? 4'hF : 4'((m_act >> (4 * k)) & 16'hF);
            e_fd  = wrap;
        end
        #1;
        chk("an", {12'h0, an}, {12'h0, e_an});
        chk("number", {12'h0, number}, {12'h0, e_num});
        chk("frame_done", {15'h0, frame_done}, {15'h0, e_fd});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
    endtask

    task automatic idle_until(input int r);
        for (int i = 0; i < FR && (m_t % FR) != r; i++) step(1'b0, 1'b0, 16'h0);
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] w;
        for (int j = 0; j < 4; j++) w[4*j +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        return w;
    endfunction

    initial begin
        m_t = 0; m_act = 0; m_pend = 0; m_pv = 0;
        repeat (3) step(1'b1, 1'b1, 16'h1234);
        step(1'b0, 1'b1, 16'h1234);
        idle(40);
        idle_until(5);
        step(1'b0, 1'b1, 16'h5678);
        idle(30);
        step(1'b0, 1'b1, 16'h1111);
        idle(3);
        step(1'b0, 1'b1, 16'h2222);
        idle(40);
        idle_until(FR - 1);
        step(1'b0, 1'b1, 16'h9999);
        idle(20);
        cur_lz = 1'b1;
        step(1'b0, 1'b1, 16'h0050);
        idle(40);
        step(1'b0, 1'b1, 16'h0000);
        idle(40);
        cur_lz = 1'b0;
        cur_bk = 4'b0100;
        idle(32);
        cur_bk = 4'b0000;
        cur_bl = 4'b0001;
        idle(80);
        cur_bl = 4'b0000;
        idle_until(9);
        step(1'b0, 1'b1, 16'hABCD);
        step(1'b1, 1'b0, 16'h0);
        idle(40);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 40) == 0) begin
                cur_bk = 4'($urandom);
                cur_bl = 4'($urandom);
                cur_lz = 1'($urandom);
            end
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0, rand_word());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
